// File: rtl/yarvi_fetch_q_if.sv
// Fetch-to-decode channel: head-of-queue handshake plus the back-end restart request.
// The fetch unit is the master; decode/back end is the slave.
interface yarvi_fetch_q_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                restart;
  logic [PC_WIDTH-1:0] restart_pc;
  logic                fe_valid;
  logic                fe_ready;
  logic [PC_WIDTH-1:0] fe_pc;
  logic [31:0]         fe_insn;

  modport master (
    input  restart, restart_pc, fe_ready,
    output fe_valid, fe_pc, fe_insn
  );

  modport slave (
    output restart, restart_pc, fe_ready,
    input  fe_valid, fe_pc, fe_insn
  );
endinterface

// File: rtl/yarvi_fetch_q.sv
// Instruction fetch unit: synchronous-read instruction RAM feeding a DEPTH-entry queue of
// {pc, insn} pairs, drained by decode over valid/ready; restart flushes and redirects.
module yarvi_fetch_q #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] INIT_PC    = 32'h8000_0000,
  parameter int unsigned         MEM_LOG2   = 10,
  parameter int unsigned         QUEUE_LOG2 = 2,
  parameter string               INIT_FILE  = "init.hex"
) (
  input logic            clock,
  input logic            reset,
  yarvi_fetch_q_if.master fe
);
  localparam int unsigned DEPTH = 1 << QUEUE_LOG2;
  localparam logic [QUEUE_LOG2+1:0] DEPTH_W = (QUEUE_LOG2 + 2)'(DEPTH);

  logic [31:0] code [2**MEM_LOG2];

  logic [PC_WIDTH-1:0]   issue_pc;
  logic                  f1_valid;
  logic [PC_WIDTH-1:0]   f1_pc;
  logic [31:0]           rdata;

  logic [PC_WIDTH-1:0]   q_pc   [DEPTH];
  logic [31:0]           q_insn [DEPTH];
  logic [QUEUE_LOG2-1:0] head;
  logic [QUEUE_LOG2-1:0] tail;
  logic [QUEUE_LOG2:0]   count;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [QUEUE_LOG2+1:0] occupancy;

  logic unused_rpc;
  assign unused_rpc = ^fe.restart_pc[1:0];

  // Credit check counts the in-flight read, so a full queue can never be overrun.
  always_comb begin
    pop       = fe.fe_valid & fe.fe_ready;
    push      = f1_valid & ~reset & ~fe.restart;
    occupancy = (QUEUE_LOG2 + 2)'(count) + (QUEUE_LOG2 + 2)'(f1_valid)
              - (QUEUE_LOG2 + 2)'(pop);
    issue     = ~reset & ~fe.restart & (occupancy < DEPTH_W);
  end

  always_ff @(posedge clock) begin
    if (issue) rdata <= code[issue_pc[MEM_LOG2+1:2]];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[tail]   <= f1_pc;
      q_insn[tail] <= rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_pc <= INIT_PC;
      f1_valid <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (fe.restart) begin
      issue_pc <= {fe.restart_pc[PC_WIDTH-1:2], 2'b00};
      f1_valid <= 1'b0;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      if (issue) begin
        f1_pc    <= issue_pc;
        issue_pc <= issue_pc + PC_WIDTH'(4);
      end
      f1_valid <= issue;
      if (push) tail <= tail + QUEUE_LOG2'(1);
      if (pop)  head <= head + QUEUE_LOG2'(1);
      count <= count + (QUEUE_LOG2 + 1)'(push) - (QUEUE_LOG2 + 1)'(pop);
    end
  end

  assign fe.fe_valid = (count != '0);
  assign fe.fe_pc    = q_pc[head];
  assign fe.fe_insn  = q_insn[head];
endmodule

// File: tb/tb_yarvi_fetch_q.sv
// Directed bench for yarvi_fetch_q: RAM[i]=i, inputs driven and outputs sampled on the
// falling edge, with hand-computed expected pc/insn values.
module tb_yarvi_fetch_q;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  yarvi_fetch_q_if #(.PC_WIDTH(32)) bus ();

  yarvi_fetch_q #(
    .PC_WIDTH  (32),
    .INIT_PC   (32'h8000_0000),
    .MEM_LOG2  (10),
    .QUEUE_LOG2(2),
    .INIT_FILE ("")
  ) dut (
    .clock(clock),
    .reset(reset),
    .fe   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in cycle 1 after a reset/restart was sampled; ends in cycle 3.
  task automatic expect_start(input string tag, input logic [31:0] pc, input logic [31:0] insn);
    chk({tag, "_c1_valid"}, 64'(bus.fe_valid), 64'd0);
    cyc();
    chk({tag, "_c2_valid"}, 64'(bus.fe_valid), 64'd0);
    cyc();
    chk({tag, "_c3_valid"}, 64'(bus.fe_valid), 64'd1);
    chk({tag, "_c3_pc"}, 64'(bus.fe_pc), 64'(pc));
    chk({tag, "_c3_insn"}, 64'(bus.fe_insn), 64'(insn));
  endtask

  task automatic restart_to(input logic [31:0] pc);
    bus.restart    = 1'b1;
    bus.restart_pc = pc;
    cyc();
    bus.restart = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 1024; i++) dut.code[i] = 32'(i);
    reset          = 1'b1;
    bus.restart    = 1'b0;
    bus.restart_pc = '0;
    bus.fe_ready   = 1'b1;

    // Two reset cycles, then stream from INIT_PC.
    repeat (2) cyc();
    reset = 1'b0;
    expect_start("reset", 32'h8000_0000, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk("stream_pc", 64'(bus.fe_pc), 64'(32'h8000_0000 + 32'(4 * k)));
      chk("stream_insn", 64'(bus.fe_insn), 64'(k));
    end

    // Backpressure: head held stable, queue fills and issue stops.
    bus.fe_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("stall_valid", 64'(bus.fe_valid), 64'd1);
      chk("stall_pc", 64'(bus.fe_pc), 64'h8000_0050);
      chk("stall_insn", 64'(bus.fe_insn), 64'd20);
    end
    chk("stall_count", 64'(dut.count), 64'd4);
    chk("stall_f1", 64'(dut.f1_valid), 64'd0);
    bus.fe_ready = 1'b1;
    for (int k = 21; k <= 28; k++) begin
      cyc();
      chk("resume_pc", 64'(bus.fe_pc), 64'(32'h8000_0000 + 32'(4 * k)));
      chk("resume_insn", 64'(bus.fe_insn), 64'(k));
    end
    chk("pre_rst_count", 64'(dut.count), 64'd3);
    chk("pre_rst_f1", 64'(dut.f1_valid), 64'd1);

    // Restart with 3 queued entries and a read in flight.
    restart_to(32'h8000_0100);
    expect_start("restart", 32'h8000_0100, 32'h40);
    cyc();
    chk("restart_next_pc", 64'(bus.fe_pc), 64'h8000_0104);
    chk("restart_next_insn", 64'(bus.fe_insn), 64'h41);

    // Back-to-back restarts: only the second target is delivered.
    bus.restart    = 1'b1;
    bus.restart_pc = 32'h8000_0300;
    cyc();
    chk("b2b_c0_valid", 64'(bus.fe_valid), 64'd0);
    bus.restart_pc = 32'h8000_0200;
    cyc();
    bus.restart = 1'b0;
    expect_start("b2b", 32'h8000_0200, 32'h80);

    // Aliasing above MEM_LOG2 and PC wrap.
    restart_to(32'h8000_1000);
    expect_start("alias", 32'h8000_1000, 32'd0);
    cyc();
    chk("alias_next_insn", 64'(bus.fe_insn), 64'd1);
    restart_to(32'hFFFF_FFF8);
    expect_start("wrap", 32'hFFFF_FFF8, 32'h3FE);
    cyc();
    chk("wrap_pc1", 64'(bus.fe_pc), 64'hFFFF_FFFC);
    chk("wrap_insn1", 64'(bus.fe_insn), 64'h3FF);
    cyc();
    chk("wrap_pc2", 64'(bus.fe_pc), 64'h0);
    chk("wrap_insn2", 64'(bus.fe_insn), 64'h0);

    // Low PC bits are ignored.
    restart_to(32'h8000_0013);
    expect_start("misalign", 32'h8000_0010, 32'd4);

    // Reset with the queue full.
    bus.fe_ready = 1'b0;
    repeat (8) cyc();
    chk("full_count", 64'(dut.count), 64'd4);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    expect_start("midreset", 32'h8000_0000, 32'd0);
    bus.fe_ready = 1'b1;
    cyc();
    chk("midreset_pc1", 64'(bus.fe_pc), 64'h8000_0004);
    chk("midreset_insn1", 64'(bus.fe_insn), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
